uart_tx_frame_sequencer: RTL
============================

Name: uart_tx_frame_sequencer

Overview:
Sits directly upstream of the UART loopback/transmit stage and feeds its transmit start and data inputs. Accepts a multi-byte result word (e.g. multiplier product) over a valid/ready handshake. Serializes the word into a UART frame: optional header byte, data bytes, XOR checksum byte. Issues one start pulse per byte and paces each byte on the transmitter's ready signal.

Parameters:
DATA_BYTES, 2, number of payload bytes per frame (1..4)
SEND_HEADER, 1, 1 = prepend HEADER_BYTE to each frame
HEADER_BYTE, 8'hA5, header value
MSB_FIRST, 1, 1 = most significant payload byte sent first
ACK_TIMEOUT, 8, cycles to wait for tx_ready to fall after a start pulse before re-issuing start

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
result_data  input  8*DATA_BYTES  payload word
result_valid  input  1  payload word available
result_ready  output  1  block can accept a word
uart_tx_ready  input  1  transmitter idle (from uart_tx)
uart_tx_start  output  1  one-cycle start pulse to transmitter
uart_tx_data  output  8  byte to transmit, stable from start pulse until tx_ready returns high
busy  output  1  frame in progress
frame_count  output  8  completed frames, wraps 255->0

Behaviour:
- One clock (clk); reset asynchronous, active-high. All outputs registered.
- Reset values: result_ready=0, uart_tx_start=0, uart_tx_data=8'h00, busy=0, frame_count=0, state=IDLE. result_ready rises on the first clk edge after reset deasserts.
- Frame length L = DATA_BYTES + SEND_HEADER + 1 (checksum).
- Checksum = XOR of payload bytes only; the header is excluded.
- States:
  - IDLE: result_ready=1. On result_valid&&result_ready, capture result_data into a shadow register, clear checksum and byte index, set busy=1, drop result_ready, go to LOAD. Input is ignored in all other states.
  - LOAD: select the next byte (header / payload per MSB_FIRST / checksum) into uart_tx_data. Go to SEND.
  - SEND: wait for uart_tx_ready=1, then pulse uart_tx_start for exactly one cycle, load the ack counter, go to WAIT_ACK.
  - WAIT_ACK: on uart_tx_ready=0, go to WAIT_DONE. If the counter expires with tx_ready still 1, return to SEND and re-issue start. The byte is unchanged.
  - WAIT_DONE: on uart_tx_ready=1, increment the byte index and accumulate the payload byte into the checksum. If the index reaches L, increment frame_count, clear busy, and go to IDLE. Otherwise go to LOAD.
- Minimum gap between accepting a word and the first start pulse is 2 cycles (LOAD, SEND).
- uart_tx_data never changes between a start pulse and the following tx_ready rise.
- result_valid held high through a frame: the next word is accepted only after return to IDLE, one word per frame, no loss.
- result_data changing mid-frame has no effect, because data is sent from the shadow register.
- Reset mid-frame: abort immediately. Start deasserts, busy=0, frame_count=0, and the partial frame is discarded.
- frame_count wraps from 8'hFF to 8'h00 without stall.

Test Plan:
- Defaults, result_data=16'h1234 with one-cycle valid, behavioural uart_tx model -> bytes A5,12,34,26 in order, exactly 4 start pulses, frame_count=1, busy low afterward.
- MSB_FIRST=0, SEND_HEADER=0, data=16'hBEEF -> bytes EF,BE,51 with 3 start pulses.
- Back-to-back: valid held high, data 16'h0001 then 16'hFF00 -> frames A5,00,01,01 then A5,FF,00,FF. result_ready low throughout each frame; no word dropped or duplicated.
- Transmitter never drops tx_ready after a start -> start re-issued every ACK_TIMEOUT+1 cycles with the same uart_tx_data; the frame completes once the model responds.
- Reset asserted during the second byte -> all outputs return to reset values within the reset assertion. The next frame after release starts with the header A5.
- Send 256 frames -> frame_count wraps to 0, and busy/ready cycle correctly for every frame.

Source files
------------

// File: rtl/uart_tx_frame_sequencer.sv
// Serialises a multi-byte result word into a UART frame: optional header, payload bytes, then an
// XOR checksum of the payload. Each byte gets one start pulse, paced by the transmitter's ready.
module uart_tx_frame_sequencer #(
  parameter int unsigned DATA_BYTES  = 2,
  parameter bit          SEND_HEADER = 1'b1,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*DATA_BYTES-1:0] result_data,
  input  logic                    result_valid,
  output logic                    result_ready,
  input  logic                    uart_tx_ready,
  output logic                    uart_tx_start,
  output logic [7:0]              uart_tx_data,
  output logic                    busy,
  output logic [7:0]              frame_count
);

  localparam int unsigned HdrLen   = SEND_HEADER ? 1 : 0;
  localparam int unsigned FrameLen = DATA_BYTES + HdrLen + 1;
  localparam int unsigned IdxW     = 3;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameLen - 1);
  // Loading Timeout-1 makes successive re-issued starts exactly ACK_TIMEOUT+1 cycles apart.
  localparam logic [15:0] AckLoad = (ACK_TIMEOUT > 0) ? 16'(ACK_TIMEOUT - 1) : 16'd0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWaitAck,
    StWaitDone
  } state_e;

  state_e                  state_q;
  logic [8*DATA_BYTES-1:0] shadow_q;
  logic [7:0]              csum_q;
  logic [IdxW-1:0]         idx_q;
  logic [15:0]             ack_cnt_q;
  logic                    is_payload_q;

  logic [7:0]  sel_byte;
  logic        sel_payload;
  int unsigned pos;
  int unsigned bi;

  // Byte for the current index: header, payload (ordered by MSB_FIRST), or running checksum.
  always_comb begin
    sel_byte    = csum_q;
    sel_payload = 1'b0;
    pos         = 0;
    bi          = 0;
    if (HdrLen != 0 && idx_q == '0) begin
      sel_byte = HEADER_BYTE;
    end else begin
      pos = 32'(idx_q) - HdrLen;
      if (pos < DATA_BYTES) begin
        sel_payload = 1'b1;
        bi = MSB_FIRST ? (DATA_BYTES - 1 - pos) : pos;
        for (int unsigned b = 0; b < DATA_BYTES; b++) begin
          if (b == bi) sel_byte = shadow_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      shadow_q      <= '0;
      csum_q        <= 8'h00;
      idx_q         <= '0;
      ack_cnt_q     <= 16'd0;
      is_payload_q  <= 1'b0;
      result_ready  <= 1'b0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
      busy          <= 1'b0;
      frame_count   <= 8'h00;
    end else begin
      uart_tx_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (result_valid && result_ready) begin
            shadow_q     <= result_data;
            csum_q       <= 8'h00;
            idx_q        <= '0;
            busy         <= 1'b1;
            result_ready <= 1'b0;
            state_q      <= StLoad;
          end else begin
            result_ready <= 1'b1;
          end
        end
        StLoad: begin
          uart_tx_data <= sel_byte;
          is_payload_q <= sel_payload;
          state_q      <= StSend;
        end
        StSend: begin
          if (uart_tx_ready) begin
            uart_tx_start <= 1'b1;
            ack_cnt_q     <= AckLoad;
            state_q       <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (!uart_tx_ready) begin
            state_q <= StWaitDone;
          end else if (ack_cnt_q == 16'd0) begin
            state_q <= StSend;
          end else begin
            ack_cnt_q <= ack_cnt_q - 16'd1;
          end
        end
        StWaitDone: begin
          if (uart_tx_ready) begin
            idx_q <= idx_q + IdxW'(1);
            if (is_payload_q) csum_q <= csum_q ^ uart_tx_data;
            if (idx_q == LastIdx) begin
              frame_count  <= frame_count + 8'd1;
              busy         <= 1'b0;
              result_ready <= 1'b1;
              state_q      <= StIdle;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
